// File: rtl/avalon_pkg.sv
// Shared types for the Avalon-MM arbitration slice.
// Response codes and arbiter state encoding.
package avalon_pkg;

    localparam logic [1:0] RESP_OKAY        = 2'b00;
    localparam logic [1:0] RESP_RESERVED    = 2'b01;
    localparam logic [1:0] RESP_SLAVEERROR  = 2'b10;
    localparam logic [1:0] RESP_DECODEERROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1,
        TOUT
    } arb_state_t;

endpackage

// File: rtl/flex_counter.sv
// Clearable up-counter; rollover_flag marks the enabled cycle whose
// increment reaches rollover_val, and the count then restarts at zero.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] count;
    logic [NUM_CNT_BITS-1:0] next_count;
    logic [NUM_CNT_BITS-1:0] count_inc;

    assign count_inc = count + NUM_CNT_BITS'(1);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else begin
            count <= next_count;
        end
    end

    always_comb begin
        next_count    = count;
        rollover_flag = 1'b0;
        if (clear) begin
            next_count = '0;
        end else if (count_enable) begin
            if (count_inc == rollover_val) begin
                rollover_flag = 1'b1;
                next_count    = '0;
            end else begin
                next_count = count_inc;
            end
        end
    end

endmodule

// File: rtl/avalon_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM slave between two masters,
// with a stall watchdog that aborts hung transfers with SLAVEERROR.
module avalon_arbiter
    import avalon_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_waitrequest,
    output logic [1:0]        m0_response,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_waitrequest,
    output logic [1:0]        m1_response,
    output logic              s_read,
    output logic              s_write,
    output logic [ADDR_W-1:0] s_address,
    output logic [DATA_W-1:0] s_writedata,
    input  logic [DATA_W-1:0] s_readdata,
    input  logic              s_waitrequest,
    input  logic [1:0]        s_response,
    output logic              timeout_flag
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_t state, next_state;
    logic       last_grant, next_last_grant;
    logic       req0, req1, owned, wd_clear, wd_stall, wd_roll;

    assign req0     = m0_read | m0_write;
    assign req1     = m1_read | m1_write;
    assign owned    = (state == OWN0) || (state == OWN1);
    assign wd_stall = owned && s_waitrequest;
    assign wd_clear = !owned || !s_waitrequest;

    flex_counter #(.NUM_CNT_BITS(CNT_W)) u_watchdog (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (wd_clear),
        .count_enable (wd_stall),
        .rollover_val (CNT_W'(TIMEOUT)),
        .rollover_flag(wd_roll)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            timeout_flag <= 1'b0;
        end else begin
            state      <= next_state;
            last_grant <= next_last_grant;
            if (state == TOUT) begin
                timeout_flag <= 1'b1;
            end
        end
    end

    // last_grant is updated on TOUT entry so TOUT knows whom to fail
    always_comb begin
        next_state      = state;
        next_last_grant = last_grant;
        s_read          = 1'b0;
        s_write         = 1'b0;
        s_address       = '0;
        s_writedata     = '0;
        m0_waitrequest  = 1'b1;
        m0_readdata     = '0;
        m0_response     = RESP_OKAY;
        m1_waitrequest  = 1'b1;
        m1_readdata     = '0;
        m1_response     = RESP_OKAY;
        unique case (state)
            IDLE: begin
                if (req0 && req1) begin
                    next_state = last_grant ? OWN0 : OWN1;
                end else if (req0) begin
                    next_state = OWN0;
                end else if (req1) begin
                    next_state = OWN1;
                end
            end
            OWN0: begin
                s_read         = m0_read;
                s_write        = m0_write;
                s_address      = m0_address;
                s_writedata    = m0_writedata;
                m0_waitrequest = s_waitrequest;
                m0_readdata    = s_readdata;
                m0_response    = s_response;
                if (!req0) begin
                    next_state = IDLE;
                end else if (!s_waitrequest) begin
                    next_last_grant = 1'b0;
                    next_state      = req1 ? OWN1 : IDLE;
                end else if (wd_roll) begin
                    next_last_grant = 1'b0;
                    next_state      = TOUT;
                end
            end
            OWN1: begin
                s_read         = m1_read;
                s_write        = m1_write;
                s_address      = m1_address;
                s_writedata    = m1_writedata;
                m1_waitrequest = s_waitrequest;
                m1_readdata    = s_readdata;
                m1_response    = s_response;
                if (!req1) begin
                    next_state = IDLE;
                end else if (!s_waitrequest) begin
                    next_last_grant = 1'b1;
                    next_state      = req0 ? OWN0 : IDLE;
                end else if (wd_roll) begin
                    next_last_grant = 1'b1;
                    next_state      = TOUT;
                end
            end
            TOUT: begin
                next_state = IDLE;
                if (last_grant) begin
                    m1_waitrequest = 1'b0;
                    m1_response    = RESP_SLAVEERROR;
                end else begin
                    m0_waitrequest = 1'b0;
                    m0_response    = RESP_SLAVEERROR;
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_avalon_arbiter.sv
// Directed plus randomized check of avalon_arbiter against a
// transaction-level reference model of the arbitration rules.
module tb_avalon_arbiter;
    import avalon_pkg::*;

    localparam int AW = 10;
    localparam int DW = 16;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          m0_read, m0_write, m1_read, m1_write;
    logic [AW-1:0] m0_address, m1_address, s_address;
    logic [DW-1:0] m0_writedata, m1_writedata, s_writedata;
    logic [DW-1:0] m0_readdata, m1_readdata, s_readdata;
    logic          m0_waitrequest, m1_waitrequest;
    logic          s_read, s_write, s_waitrequest, timeout_flag;
    logic [1:0]    m0_response, m1_response, s_response;

    avalon_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .m0_read       (m0_read),
        .m0_write      (m0_write),
        .m0_address    (m0_address),
        .m0_writedata  (m0_writedata),
        .m0_readdata   (m0_readdata),
        .m0_waitrequest(m0_waitrequest),
        .m0_response   (m0_response),
        .m1_read       (m1_read),
        .m1_write      (m1_write),
        .m1_address    (m1_address),
        .m1_writedata  (m1_writedata),
        .m1_readdata   (m1_readdata),
        .m1_waitrequest(m1_waitrequest),
        .m1_response   (m1_response),
        .s_read        (s_read),
        .s_write       (s_write),
        .s_address     (s_address),
        .s_writedata   (s_writedata),
        .s_readdata    (s_readdata),
        .s_waitrequest (s_waitrequest),
        .s_response    (s_response),
        .timeout_flag  (timeout_flag)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // model: own = -1 idle / 0 / 1; tout marks the abort cycle for 'who'
    int own, lg, stalls, who;
    bit tout, flag;
    bit done [2];
    logic [DW-1:0] seen [$];

    logic          c_rd [2];
    logic          c_wr [2];
    logic [AW-1:0] c_a  [2];
    logic [DW-1:0] c_d  [2];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic apply();
        m0_read = c_rd[0]; m0_write = c_wr[0];
        m0_address = c_a[0]; m0_writedata = c_d[0];
        m1_read = c_rd[1]; m1_write = c_wr[1];
        m1_address = c_a[1]; m1_writedata = c_d[1];
    endtask

    task automatic model_reset();
        own = -1; lg = 1; stalls = 0; who = 0;
        tout = 1'b0; flag = 1'b0;
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_sr"}, s_read, 0);
        chk({tag, "_sw"}, s_write, 0);
        chk({tag, "_sa"}, s_address, 0);
        chk({tag, "_sd"}, s_writedata, 0);
        chk({tag, "_w0"}, m0_waitrequest, 1);
        chk({tag, "_w1"}, m1_waitrequest, 1);
        chk({tag, "_rd0"}, m0_readdata, 0);
        chk({tag, "_rd1"}, m1_readdata, 0);
        chk({tag, "_rs0"}, m0_response, 0);
        chk({tag, "_rs1"}, m1_response, 0);
        chk({tag, "_flag"}, timeout_flag, 0);
    endtask

    task automatic check_cycle();
        logic          ewr [2];
        logic [DW-1:0] erd [2];
        logic [1:0]    ers [2];
        logic          esr, esw;
        logic [AW-1:0] esa;
        logic [DW-1:0] esd;
        ewr = '{1'b1, 1'b1};
        erd = '{'0, '0};
        ers = '{2'b00, 2'b00};
        esr = 1'b0; esw = 1'b0; esa = '0; esd = '0;
        if (tout) begin
            ewr[who] = 1'b0;
            ers[who] = 2'b10;
        end else if (own >= 0) begin
            esr = c_rd[own]; esw = c_wr[own];
            esa = c_a[own];  esd = c_d[own];
            ewr[own] = s_waitrequest;
            erd[own] = s_readdata;
            ers[own] = s_response;
        end
        chk("s_read", s_read, esr);
        chk("s_write", s_write, esw);
        if (!tout) begin
            chk("s_address", s_address, esa);
            chk("s_writedata", s_writedata, esd);
        end
        chk("m0_wait", m0_waitrequest, ewr[0]);
        chk("m1_wait", m1_waitrequest, ewr[1]);
        chk("m0_rdata", m0_readdata, erd[0]);
        chk("m1_rdata", m1_readdata, erd[1]);
        chk("m0_resp", m0_response, ers[0]);
        chk("m1_resp", m1_response, ers[1]);
        chk("tflag", timeout_flag, flag);
    endtask

    task automatic advance();
        bit r [2];
        int o;
        r[0] = c_rd[0] | c_wr[0];
        r[1] = c_rd[1] | c_wr[1];
        done[0] = 1'b0;
        done[1] = 1'b0;
        o = own;
        if (tout) begin
            tout = 1'b0;
            flag = 1'b1;
            own = -1;
        end else if (o < 0) begin
            stalls = 0;
            if (r[0] && r[1]) own = (lg == 1) ? 0 : 1;
            else if (r[0]) own = 0;
            else if (r[1]) own = 1;
        end else if (!r[o]) begin
            own = -1;
        end else if (!s_waitrequest) begin
            done[o] = 1'b1;
            if (c_wr[o]) seen.push_back(s_writedata);
            lg = o;
            stalls = 0;
            own = r[1-o] ? 1 - o : -1;
        end else begin
            stalls++;
            if (stalls == TO) begin
                tout = 1'b1;
                who = o;
                lg = o;
                done[o] = 1'b1;
                own = -1;
            end
        end
    endtask

    task automatic cyc();
        apply();
        #2;
        check_cycle();
        advance();
        @(posedge clk);
        #1;
    endtask

    int t, k0, k1, p, op;

    initial begin
        n_rst = 1'b0;
        for (int m = 0; m < 2; m++) begin
            c_rd[m] = 1'b0; c_wr[m] = 1'b0; c_a[m] = '0; c_d[m] = '0;
        end
        s_waitrequest = 1'b0; s_readdata = '0; s_response = 2'b00;
        apply();
        model_reset();
        #1;
        reset_vals("por");
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        cyc();

        // single zero-wait write from m0
        c_wr[0] = 1'b1; c_a[0] = 10'h2FF; c_d[0] = 16'h0042;
        cyc();
        apply(); #1;
        chk("t1_sw", s_write, 1);
        chk("t1_sa", s_address, 10'h2FF);
        chk("t1_sd", s_writedata, 16'h0042);
        chk("t1_w0", m0_waitrequest, 0);
        cyc();
        c_wr[0] = 1'b0;
        cyc();

        // sustained contention, 4 writes each
        seen.delete();
        k0 = 0; k1 = 0;
        c_wr[0] = 1'b1; c_a[0] = '0; c_d[0] = 16'hA000;
        for (t = 0; t < 30 && (k0 < 4 || k1 < 4); t++) begin
            if (t == 1) begin
                c_wr[1] = 1'b1; c_a[1] = '0; c_d[1] = 16'hB000;
            end
            cyc();
            if (done[0]) begin
                k0++;
                if (k0 < 4) begin
                    c_a[0] = AW'(k0); c_d[0] = 16'hA000 + DW'(k0);
                end else c_wr[0] = 1'b0;
            end
            if (done[1]) begin
                k1++;
                if (k1 < 4) begin
                    c_a[1] = AW'(k1); c_d[1] = 16'hB000 + DW'(k1);
                end else c_wr[1] = 1'b0;
            end
        end
        chk("rr_cycles", t, 9);
        chk("rr_len", seen.size(), 8);
        for (int i = 0; i < 8 && i < seen.size(); i++) begin
            chk("rr_order", seen[i],
                ((i % 2) ? 16'hB000 : 16'hA000) + 16'(i / 2));
        end
        cyc();

        // m1 read with 5 wait states while m0 is pending
        c_rd[1] = 1'b1; c_a[1] = 10'h010; s_waitrequest = 1'b1;
        cyc();
        c_wr[0] = 1'b1; c_a[0] = 10'h123; c_d[0] = 16'h5555;
        repeat (5) cyc();
        s_waitrequest = 1'b0; s_readdata = 16'hBEEF; s_response = 2'b00;
        apply(); #1;
        chk("rd_data", m1_readdata, 16'hBEEF);
        chk("rd_hold0", m0_waitrequest, 1);
        cyc();
        c_rd[1] = 1'b0; s_readdata = '0;
        apply(); #1;
        chk("m0_next_sw", s_write, 1);
        chk("m0_next_sa", s_address, 10'h123);
        cyc();
        c_wr[0] = 1'b0;
        cyc();

        // watchdog abort on m0
        c_wr[0] = 1'b1; c_a[0] = 10'h3AA; c_d[0] = 16'h1234;
        s_waitrequest = 1'b1;
        cyc();
        repeat (TO) cyc();
        apply(); #1;
        chk("to_resp", m0_response, 2'b10);
        chk("to_w0", m0_waitrequest, 0);
        chk("to_sw", s_write, 0);
        cyc();
        c_wr[0] = 1'b0; c_rd[1] = 1'b1; c_a[1] = 10'h055;
        s_waitrequest = 1'b0; s_readdata = 16'h7777;
        cyc();
        apply(); #1;
        chk("post_to_rd", m1_readdata, 16'h7777);
        chk("post_to_w1", m1_waitrequest, 0);
        chk("post_to_flag", timeout_flag, 1);
        cyc();
        c_rd[1] = 1'b0;
        cyc();

        // asynchronous reset while m1 owns a stalled slave
        c_rd[1] = 1'b1; c_a[1] = 10'h0F0; s_waitrequest = 1'b1;
        cyc();
        c_wr[0] = 1'b1; c_a[0] = 10'h011; c_d[0] = 16'h0F0F;
        cyc();
        cyc();
        apply(); #1;
        chk("pre_rst_sr", s_read, 1);
        #1;
        n_rst = 1'b0;
        #1;
        reset_vals("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        reset_vals("rst_hold");
        n_rst = 1'b1;
        cyc();
        apply(); #1;
        chk("tie_m0_sw", s_write, 1);
        chk("tie_m1_w", m1_waitrequest, 1);
        s_waitrequest = 1'b0;
        cyc();
        c_wr[0] = 1'b0;
        cyc();
        c_rd[1] = 1'b0;
        cyc();

        // randomized traffic
        p = 0;
        for (int i = 0; i < 600; i++) begin
            if (i % 40 == 0) begin
                case ($urandom_range(0, 2))
                    0: p = 0;
                    1: p = 50;
                    default: p = 97;
                endcase
            end
            s_waitrequest = ($urandom_range(0, 99) < p);
            s_readdata = DW'($urandom);
            s_response = 2'($urandom);
            for (int m = 0; m < 2; m++) begin
                if (c_rd[m] | c_wr[m]) begin
                    if ($urandom_range(0, 29) == 0) begin
                        c_rd[m] = 1'b0; c_wr[m] = 1'b0;
                    end
                end else if ($urandom_range(0, 1) == 1) begin
                    op = $urandom_range(0, 2);
                    c_rd[m] = (op != 1);
                    c_wr[m] = (op != 0);
                    c_a[m] = AW'($urandom);
                    c_d[m] = DW'($urandom);
                end
            end
            cyc();
            for (int m = 0; m < 2; m++) begin
                if (done[m]) begin
                    c_rd[m] = 1'b0; c_wr[m] = 1'b0;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
